fetch_pc_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined processor.
- Holds the PC and drives the instruction-memory address. Selects next PC from PC+4, branch target or jump target.
- Registers the fetched instruction into the IF/ID pipeline register.
- Sits directly downstream of the shift-left-2 unit: consumes the already-shifted branch offset and adds it to the branch's PC+4.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 107 ++++++++++
 tb/tb_fetch_pc_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and pipeline-register payload types for the CPU pipeline.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    // IF/ID payload: PC+4 of the fetched instruction, the instruction, and a real/bubble flag.
    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    // Bubble payload written on reset or flush.
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.pc4   = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage : cpu_pkg

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with reset, flush, hold and load controls.
// Priority: reset > flush > hold > load.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  flush_i,
    input  logic  hold_i,
    input  ifid_t load_i,
    output ifid_t q_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next-value select: flush squashes, hold keeps, otherwise capture the new fetch.
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = ifid_bubble(BUBBLE_INSTR);
        end else if (!hold_i) begin
            ifid_d = load_i;
        end
    end

    // State register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= ifid_bubble(BUBBLE_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule : ifid_reg

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC select (PC+4 / branch / jump),
// IF/ID pipeline register and a saturating redirect counter.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_base_i,
    input  logic [31:0]      branch_offset_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_index_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    import cpu_pkg::ifid_t;
    import cpu_pkg::PC_INC;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [31:0] pc4_c;
    logic [31:0] btarget_c;
    logic [31:0] jtarget_c;
    logic        redirect_c;

    ifid_t ifid_load;
    ifid_t ifid_out;

    // Target adders; all wrap modulo 2^32.
    always_comb begin
        pc4_c      = pc_q + PC_INC;
        btarget_c  = branch_base_i + branch_offset_i;
        jtarget_c  = {ifid_out.pc4[31:28], jump_index_i, 2'b00};
        redirect_c = branch_taken_i | jump_i;
    end

    // Next-PC select: branch beats jump, any redirect beats stall.
    always_comb begin
        pc_d = pc4_c;
        if (branch_taken_i) begin
            pc_d = btarget_c;
        end else if (jump_i) begin
            pc_d = jtarget_c;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // Redirect counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // PC and counter registers; reset discards any redirect or stall on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload captured on a normal fetch.
    always_comb begin
        ifid_load.pc4   = pc4_c;
        ifid_load.instr = instr_i;
        ifid_load.valid = 1'b1;
    end

    // IF/ID register: a redirect squashes the single wrong-path fetch.
    ifid_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_c),
        .hold_i  (stall_i),
        .load_i  (ifid_load),
        .q_o     (ifid_out)
    );

    assign pc_o           = pc_q;
    assign ifid_pc4_o     = ifid_out.pc4;
    assign ifid_instr_o   = ifid_out.instr;
    assign ifid_valid_o   = ifid_out.valid;
    assign redirect_cnt_o = cnt_q;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    localparam int unsigned CNT_W = 16;
    localparam int          NVEC  = 19;

    logic             clk;
    logic             reset;
    logic             stall_i;
    logic             branch_taken_i;
    logic [31:0]      branch_base_i;
    logic [31:0]      branch_offset_i;
    logic             jump_i;
    logic [25:0]      jump_index_i;
    logic [31:0]      instr_i;
    logic [31:0]      pc_o;
    logic [31:0]      ifid_pc4_o;
    logic [31:0]      ifid_instr_o;
    logic             ifid_valid_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    int n_cmp;
    int n_err;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_base_i   (branch_base_i),
        .branch_offset_i (branch_offset_i),
        .jump_i          (jump_i),
        .jump_index_i    (jump_index_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_valid_o    (ifid_valid_o),
        .redirect_cnt_o  (redirect_cnt_o)
    );

    // Instruction memory model: word tagged with the low half of its address.
    assign instr_i = {16'hC0DE, pc_o[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] base;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic jmp, input logic [25:0] idx,
                                input logic [31:0] e_pc, input logic [31:0] e_pc4,
                                input logic [31:0] e_instr, input logic e_valid,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.base = base; v.off = off;
        v.jmp = jmp; v.idx = idx; v.e_pc = e_pc; v.e_pc4 = e_pc4;
        v.e_instr = e_instr; v.e_valid = e_valid; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic jmp, input logic [25:0] idx);
        reset           = rst;
        stall_i         = stall;
        branch_taken_i  = br;
        branch_base_i   = base;
        branch_offset_i = off;
        jump_i          = jmp;
        jump_index_i    = idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                           input logic [31:0] e_instr, input logic e_valid, input logic [15:0] e_cnt);
        chk({tag, ".pc"},    pc_o,                   e_pc);
        chk({tag, ".pc4"},   ifid_pc4_o,             e_pc4);
        chk({tag, ".instr"}, ifid_instr_o,           e_instr);
        chk({tag, ".valid"}, 32'(ifid_valid_o),      32'(e_valid));
        chk({tag, ".cnt"},   32'(redirect_cnt_o),    32'(e_cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);

        //            rst   stl   br    base           off            jmp   idx         pc             pc4            instr          v     cnt
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h0,         32'h0,         32'h0,         1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h4,         32'h4,         32'hC0DE_0000, 1'b1, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h8,         32'h8,         32'hC0DE_0004, 1'b1, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'hC,         32'hC,         32'hC0DE_0008, 1'b1, 16'd0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h10,        32'h10,        32'hC0DE_000C, 1'b1, 16'd0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h10,        32'h10,        32'hC0DE_000C, 1'b1, 16'd0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h10,        32'h10,        32'hC0DE_000C, 1'b1, 16'd0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h14,        32'h14,        32'hC0DE_0010, 1'b1, 16'd0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 32'h24,        32'hFFFF_FFF0, 1'b0, 26'h0,      32'h14,        32'h0,         32'h0,         1'b0, 16'd1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h18,        32'h18,        32'hC0DE_0014, 1'b1, 16'd1);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h4,         1'b0, 26'h0,      32'h4000_0004, 32'h0,         32'h0,         1'b0, 16'd2);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h4000_0008, 32'h4000_0008, 32'hC0DE_0004, 1'b1, 16'd2);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 26'h100,    32'h4000_0400, 32'h0,         32'h0,         1'b0, 16'd3);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h4000_0404, 32'h4000_0404, 32'hC0DE_0400, 1'b1, 16'd3);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h4000_0408, 32'h4000_0408, 32'hC0DE_0404, 1'b1, 16'd3);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'h100,       32'h20,        1'b1, 26'h100,    32'h120,       32'h0,         32'h0,         1'b0, 16'd4);
        vecs[16] = mk(1'b1, 1'b1, 1'b1, 32'h200,       32'h20,        1'b1, 26'h55,     32'h0,         32'h0,         32'h0,         1'b0, 16'd0);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 26'h40,     32'h100,       32'h0,         32'h0,         1'b0, 16'd1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 26'h0,      32'h104,       32'h104,       32'hC0DE_0100, 1'b1, 16'd1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].base, vecs[i].off,
                  vecs[i].jmp, vecs[i].idx);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pc4,
                    vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_cnt);
        end

        // PC+4 wraps from the top of the address space to zero.
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hC, 1'b0, 26'h0);
        step();
        chk_all("wrap_br", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd2);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
        step();
        chk_all("wrap_run", 32'h0, 32'h0, 32'hC0DE_FFFC, 1'b1, 16'd2);
        step();
        chk_all("wrap_run2", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1, 16'd2);

        // Counter saturation: 2^16 + 3 redirects from a clean reset.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
        step();
        chk("sat_reset.cnt", 32'(redirect_cnt_o), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 26'h0);
        for (int k = 1; k <= 65539; k++) begin
            step();
            if (k == 1)     chk("sat_k1.cnt",     32'(redirect_cnt_o), 32'h1);
            if (k == 65534) chk("sat_k65534.cnt", 32'(redirect_cnt_o), 32'hFFFE);
            if (k == 65535) chk("sat_k65535.cnt", 32'(redirect_cnt_o), 32'hFFFF);
        end
        chk("sat_end.cnt", 32'(redirect_cnt_o), 32'hFFFF);
        chk("sat_end.pc",  pc_o, 32'h0);
        chk("sat_end.valid", 32'(ifid_valid_o), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 26'h0);
        step();
        chk("sat_clr.cnt", 32'(redirect_cnt_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_pc_unit
